// File: rtl/line_buffer.sv
// line_buffer: N_LINES-tall column generator over a raster stream, N_LINES-1 shifted line banks.
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_LEN   = 128,
  parameter int N_LINES    = 3,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sof,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  output logic [N_LINES*DATA_WIDTH-1:0] out_col,
  output logic [ADDR_WIDTH-1:0]         out_x,
  output logic                          out_eol,
  output logic                          out_full
);
  localparam int YW = $clog2(N_LINES);
  logic [ADDR_WIDTH-1:0]         x, cx;
  logic [YW-1:0]                 y, cy;
  logic                          last;
  logic [N_LINES*DATA_WIDTH-1:0] col;
  logic [DATA_WIDTH-1:0]         mem [N_LINES-1][LINE_LEN];
  // sof restarts the position combinationally so a same-cycle pixel lands at (0,0)
  assign cx   = sof ? '0 : x;
  assign cy   = sof ? '0 : y;
  assign last = cx == ADDR_WIDTH'(LINE_LEN - 1);
  assign col[DATA_WIDTH-1:0] = in_data;
  for (genvar g = 1; g < N_LINES; g++) begin : g_slice
    assign col[g*DATA_WIDTH +: DATA_WIDTH] = cy >= YW'(g) ? mem[g-1][cx] : '0;
  end
  // bank k holds the line k+1 back; each pixel shifts the column down one bank
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[0][cx] <= in_data;
      for (int k = 1; k < N_LINES - 1; k++) mem[k][cx] <= mem[k-1][cx];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_x     <= '0;
      out_eol   <= 1'b0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        x        <= last ? '0 : cx + 1'b1;
        y        <= (last && cy != YW'(N_LINES - 1)) ? cy + 1'b1 : cy;
        out_col  <= col;
        out_x    <= cx;
        out_eol  <= last;
        out_full <= cy == YW'(N_LINES - 1);
      end else begin
        x <= cx;
        y <= cy;
      end
    end
  end
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed and random stream against a frame-history model of the column buffer.
module tb_line_buffer;
  logic        clk = 0, rst = 1, sof = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        out_valid, out_eol, out_full;
  logic [23:0] out_col;
  logic [1:0]  out_x;
  int          checks = 0, errors = 0;

  line_buffer #(.DATA_WIDTH(8), .LINE_LEN(4), .N_LINES(3), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_col(out_col), .out_x(out_x), .out_eol(out_eol), .out_full(out_full)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: n = pixels accepted in this frame; pixel n sits at row n/4, column n%4
  int          n, nn;
  logic [7:0]  hist [64][4];
  logic        exp_v, exp_eol, exp_full;
  logic [23:0] exp_col;
  logic [1:0]  exp_x;
  assign nn = sof ? 0 : n;

  function automatic logic [23:0] mcol(int m, logic [7:0] d);
    int r = m / 4, c = m % 4;
    mcol[7:0] = d;
    for (int k = 1; k < 3; k++) mcol[k*8 +: 8] = r >= k ? hist[(r - k) % 64][c] : 8'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0; exp_v <= 0; exp_col <= 0; exp_x <= 0; exp_eol <= 0; exp_full <= 0;
    end else begin
      exp_v <= in_valid;
      if (in_valid) begin
        exp_col               <= mcol(nn, in_data);
        hist[(nn/4)%64][nn%4] <= in_data;
        exp_x                 <= 2'(nn % 4);
        exp_eol               <= nn % 4 == 3;
        exp_full              <= nn / 4 >= 2;
        n                     <= nn + 1;
      end else n <= nn;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(out_valid), 32'(exp_v));
      chk("col", 32'(out_col), 32'(exp_col));
      if (exp_v) begin
        chk("x", 32'(out_x), 32'(exp_x));
        chk("eol", 32'(out_eol), 32'(exp_eol));
        chk("full", 32'(out_full), 32'(exp_full));
      end
    end
  end

  task automatic px(logic s, logic v, logic [7:0] d);
    sof = s; in_valid = v; in_data = d;
    @(posedge clk); #1;
    sof = 0; in_valid = 0;
  endtask

  task automatic lit(string nm, logic [23:0] col, logic [1:0] x, logic eol, logic full);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_col"}, 32'(out_col), 32'(col));
    chk({nm, "_x"}, 32'(out_x), 32'(x));
    chk({nm, "_eol"}, 32'(out_eol), 32'(eol));
    chk({nm, "_full"}, 32'(out_full), 32'(full));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_col", 32'(out_col), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_eol", 32'(out_eol), 0);
    chk("rst_full", 32'(out_full), 0);
    @(posedge clk); #1;
    px(0, 1, 8'h11);
    lit("first", 24'h000011, 0, 0, 0);
    for (int i = 1; i <= 13; i++) begin
      px(i == 1, 1, 8'(i));
      if (i == 4)  lit("p4", 24'h000004, 3, 1, 0);
      if (i == 5)  lit("p5", 24'h000105, 0, 0, 0);
      if (i == 9)  lit("p9", 24'h010509, 0, 0, 1);
      if (i == 12) lit("p12", 24'h04080c, 3, 1, 1);
      if (i == 13) lit("p13", 24'h05090d, 0, 0, 1);
    end
    px(1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      px(0, 1, 8'(i));
      if (i == 9) lit("g9", 24'h010509, 0, 0, 1);
      if (i == 12) lit("g12", 24'h04080c, 3, 1, 1);
      px(0, 0, 8'hee);
      chk("gap_valid", 32'(out_valid), 0);
      px(0, 0, 8'hdd);
    end
    for (int i = 1; i <= 6; i++) px(i == 1, 1, 8'(i + 20));
    px(1, 1, 8'h64);
    lit("sof", 24'h000064, 0, 0, 0);
    px(0, 1, 8'h65);
    px(0, 1, 8'h66);
    #2 rst = 1;
    #1 chk("arst_valid", 32'(out_valid), 0);
    chk("arst_col", 32'(out_col), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    px(0, 1, 8'h77);
    lit("after_rst", 24'h000077, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      px($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_buffer.md
# line_buffer

- Parametrised multi-line buffer for the 2D FIR datapath.
- Accepts a raster pixel stream, one pixel per valid cycle, and stores the previous N_LINES-1 lines in internal SRAM banks.
- For every accepted pixel it emits a vertical column of N_LINES pixels at the same x position: the current pixel plus the pixels from 1..N_LINES-1 lines earlier.
- Sits between the pixel source and the horizontal FIR tap stage. Generalises the single 16x128 dual-clock memory to configurable width, line length and line count on one clock, with position tracking and frame restart.

## Interface
- DATA_WIDTH, 16, pixel width in bits.
- LINE_LEN, 128, pixels per line. Legal range 2..2^ADDR_WIDTH.
- N_LINES, 3, column height. Legal range 2..8. Number of stored lines = N_LINES-1.
- ADDR_WIDTH, 7, column counter and memory address width.
- clk  in  1  single clock. All logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sof  in  1  start of frame; synchronous counter restart.
- in_valid  in  1  in_data is accepted this cycle.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  out_col, out_x and out_eol are valid.
- out_col  out  N_LINES*DATA_WIDTH  slice k, bits [k*DATA_WIDTH +: DATA_WIDTH], is the pixel from k lines ago at the same x. Slice 0 is the current pixel.
- out_x  out  ADDR_WIDTH  column index of the emitted column.
- out_eol  out  1  emitted column is the last column of its line (x = LINE_LEN-1).
- out_full  out  1  every slice of the emitted column holds real frame data (row >= N_LINES-1).

## Operation
- State:
  - column counter x, range 0..LINE_LEN-1;
  - row counter y, saturating at N_LINES-1;
  - N_LINES-1 banks of LINE_LEN x DATA_WIDTH.
- Accepted pixel (in_valid=1) at (x, y):
  - slice 0 = in_data;
  - slice k = pixel accepted at column x exactly k lines earlier in the current frame;
  - slice k is forced to 0 when y < k. Stale memory from a previous frame or from reset must never appear; no memory clear is required.
- Line storage is updated in the same cycle:
  - bank k ends up holding the pixel from k+1 lines ago at x;
  - read-before-write per address; banks may rotate or shift, implementer's choice.
- Counter advance on each accepted pixel:
  - x increments;
  - at x = LINE_LEN-1, x wraps to 0 and y increments, saturating at N_LINES-1.
- sof=1:
  - x and y are cleared;
  - if in_valid=1 in the same cycle, that pixel is (0,0);
  - if in_valid=0, the next accepted pixel is (0,0).
  - sof on a non-line boundary abandons the partial line.
- in_valid=0: counters, memory and out_col hold; out_valid=0.
- Arithmetic is unsigned. No data modification: pixels pass through bit-exact.

## Timing
- Reset values: out_valid=0, out_col=0, out_x=0, out_eol=0, out_full=0; internal x=0, y=0. Memory contents are undefined and masked by the y rule.
- Latency: exactly 1 cycle. out_* are registered from the cycle in which in_valid=1.
- Throughput: 1 pixel per cycle, sustained indefinitely. No backpressure; the downstream stage must accept every out_valid.
- Line wrap:
  - pixel at x=LINE_LEN-1 → out_eol=1 on that output cycle;
  - next accepted pixel → out_x=0.
- out_full = 1 for every output whose y = N_LINES-1. It stays 1 until sof or rst.
- rst mid-line: outputs clear immediately (asynchronous). The first pixel after release is (0,0) with upper slices zero.
- sof and rst both asserted: rst wins.

## Test plan
Bench configuration: DATA_WIDTH=8, LINE_LEN=4, N_LINES=3, ADDR_WIDTH=2.
- Apply rst, then release. All outputs = 0. First pixel 0x11 → next cycle out_valid=1, out_col={0,0,0x11}, out_x=0, out_full=0.
- Stream pixels 1..12 back-to-back after sof. Required responses:
  - pixel 5 → {0,1,5}, out_x=0;
  - pixel 4 → out_eol=1;
  - pixel 9 → {1,5,9}, out_full=1;
  - pixel 12 → {4,8,12}, out_eol=1.
- Continue with pixel 13. Output is {5,9,13}, out_full=1, confirming y saturation and line rotation.
- Repeat the 1..12 stream with in_valid toggling 1,0,0,1,... Output values are identical. out_valid pulses only one cycle after each accepted pixel, and out_col holds between pulses.
- After 6 pixels, assert sof with in_valid and pixel 0x64. Output is {0,0,0x64}, out_x=0, out_full=0; the old lines do not leak.
- Assert rst asynchronously mid-line (x=2). out_valid and out_col = 0 with no clock edge. The next pixel is reported at out_x=0.
